bus_arb2: RTL and testbench

Two-master, three-slave bus arbiter and interconnect for the matrix subsystem. It decides which master owns the shared bus: M0 is the host/testbench port, M1 is the matrix engine's memory master. It muxes the owner's address, write and data onto the slave side and decodes the address into slave selects. It returns registered slave read data to both masters on `M_din`.

---
 rtl/bus_arb2.sv | 209 ++++++++++++++++++++
 tb/tb_bus_arb2.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb2.sv
// -----------------------------------------------------------------------------
// bus_arb2 - two-master / three-slave bus arbiter and interconnect
//
// M0 (host port) and M1 (matrix engine memory master) share one slave bus.
// Ownership is a registered two-state FSM. The bus parks on M0. M1 takes the
// bus whenever M0 is idle and keeps it until it drops its own request, so M1
// bursts are never broken up. The owner's write/address/data are forwarded
// combinationally to the slaves. The address is decoded into one of three
// slave selects. Slave read data is steered back onto M_din one cycle later.
//
// Optional feature (compile-time macro ARB_STARVE_GUARD_EN):
//   When defined, a hold counter limits how long M0 can keep the bus while
//   M1 is waiting. After MAX_HOLD owned cycles the bus is handed to M1.
//   When undefined, M0 has strict priority and MAX_HOLD has no effect.
//
// Parameters:
//   MAX_HOLD   M0 owned cycles before a forced handover, range 2..255.
//
// Ports:
//   clk                     rising-edge clock
//   reset                   synchronous active-high reset
//   M0_req / M1_req         bus requests
//   M0_wr / M1_wr           1 = write, 0 = read
//   M0_address/M1_address   8-bit word address
//   M0_dout / M1_dout       32-bit write data
//   M0_grant / M1_grant     registered grants, exactly one high
//   M_din                   read data returned to both masters
//   S0_sel/S1_sel/S2_sel    slave selects
//                           S0 = 0x00-0x1F, S1 = 0x20-0x3F, S2 = 0x40-0x5F
//   S_wr/S_address/S_dout   owner's signals, forwarded to the slaves
//   S0_dout/S1_dout/S2_dout slave read data, valid one cycle after select
// -----------------------------------------------------------------------------
module bus_arb2 #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M0_req,
    input  logic        M1_req,
    input  logic        M0_wr,
    input  logic        M1_wr,
    input  logic [7:0]  M0_address,
    input  logic [7:0]  M1_address,
    input  logic [31:0] M0_dout,
    input  logic [31:0] M1_dout,
    output logic        M0_grant,
    output logic        M1_grant,
    output logic [31:0] M_din,
    output logic        S0_sel,
    output logic        S1_sel,
    output logic        S2_sel,
    output logic        S_wr,
    output logic [7:0]  S_address,
    output logic [31:0] S_dout,
    input  logic [31:0] S0_dout,
    input  logic [31:0] S1_dout,
    input  logic [31:0] S2_dout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arb2: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        RSEL_NONE = 2'd0,
        RSEL_S0   = 2'd1,
        RSEL_S1   = 2'd2,
        RSEL_S2   = 2'd3
    } rsel_t;

    state_t      state_reg, state_next;
    rsel_t       rsel_reg, rsel_next;
    logic        owner_req;
    logic        fwd_wr;
    logic [7:0]  fwd_address;
    logic [31:0] fwd_dout;
    logic [2:0]  sel_vec;
    logic        force_handover;

    // ---------------------------------------------------------------------
    // Owner forwarding. This is driven from the registered state only, so
    // the non-owner's inputs can never leak onto the slave side.
    // ---------------------------------------------------------------------
    always_comb begin
        owner_req   = M0_req;
        fwd_wr      = M0_wr;
        fwd_address = M0_address;
        fwd_dout    = M0_dout;
        if (state_reg == OWN_M1) begin
            owner_req   = M1_req;
            fwd_wr      = M1_wr;
            fwd_address = M1_address;
            fwd_dout    = M1_dout;
        end
    end

    assign S_wr      = fwd_wr;
    assign S_address = fwd_address;
    assign S_dout    = fwd_dout;

    // Address decode on the top three bits. Values 3..7 select nothing.
    for (genvar gi = 0; gi < 3; gi++) begin : g_decode
        assign sel_vec[gi] = owner_req && (fwd_address[7:5] == 3'(gi));
    end

    assign S0_sel = sel_vec[0];
    assign S1_sel = sel_vec[1];
    assign S2_sel = sel_vec[2];

    // ---------------------------------------------------------------------
    // Starvation guard
    // ---------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_reg, hold_cnt_next;

    // hold_cnt only advances in OWN_M0, so reaching HOLD_LAST implies M0
    // has already owned the bus for MAX_HOLD-1 contested cycles. This cycle
    // is the last one it gets.
    assign force_handover = M0_req && M1_req && (hold_cnt_reg == HOLD_LAST);

    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (!M0_req || !M1_req || (state_next != state_reg)) begin
            hold_cnt_next = 8'd0;
        end else if (state_reg == OWN_M0 && hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_reg <= 8'd0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
        end
    end
`else
    assign force_handover = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Ownership FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            OWN_M0: begin
                if ((!M0_req && M1_req) || force_handover) begin
                    state_next = OWN_M1;
                end
            end
            OWN_M1: begin
                // No preemption: engine bursts are atomic.
                if (!M1_req) begin
                    state_next = OWN_M0;
                end
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Read-return steering. One rsel entry per cycle, so back-to-back reads
    // pipeline naturally. A read issued in the last cycle before a handover
    // still returns its data on M_din.
    // ---------------------------------------------------------------------
    always_comb begin
        rsel_next = RSEL_NONE;
        if (owner_req && !fwd_wr) begin
            if (sel_vec[0]) begin
                rsel_next = RSEL_S0;
            end else if (sel_vec[1]) begin
                rsel_next = RSEL_S1;
            end else if (sel_vec[2]) begin
                rsel_next = RSEL_S2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= OWN_M0;
            rsel_reg  <= RSEL_NONE;
        end else begin
            state_reg <= state_next;
            rsel_reg  <= rsel_next;
        end
    end

    assign M0_grant = (state_reg == OWN_M0);
    assign M1_grant = (state_reg == OWN_M1);

    always_comb begin
        M_din = 32'd0;
        unique case (rsel_reg)
            RSEL_S0:   M_din = S0_dout;
            RSEL_S1:   M_din = S1_dout;
            RSEL_S2:   M_din = S2_dout;
            RSEL_NONE: M_din = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_bus_arb2.sv
// -----------------------------------------------------------------------------
// tb_bus_arb2 - directed self-checking bench for bus_arb2 (MAX_HOLD = 4).
// Slave models: S0 and S2 return a fixed tag OR'd with the address, and
// S1 is a 32-word RAM. All three register their read data one cycle after
// select, as real slaves would.
// -----------------------------------------------------------------------------
module tb_bus_arb2;

    logic        clk = 1'b0;
    logic        reset;
    logic        M0_req, M1_req, M0_wr, M1_wr;
    logic [7:0]  M0_address, M1_address;
    logic [31:0] M0_dout, M1_dout;
    logic        M0_grant, M1_grant;
    logic [31:0] M_din;
    logic        S0_sel, S1_sel, S2_sel;
    logic        S_wr;
    logic [7:0]  S_address;
    logic [31:0] S_dout;
    logic [31:0] S0_dout, S1_dout, S2_dout;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    bus_arb2 #(.MAX_HOLD(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .M0_req     (M0_req),
        .M1_req     (M1_req),
        .M0_wr      (M0_wr),
        .M1_wr      (M1_wr),
        .M0_address (M0_address),
        .M1_address (M1_address),
        .M0_dout    (M0_dout),
        .M1_dout    (M1_dout),
        .M0_grant   (M0_grant),
        .M1_grant   (M1_grant),
        .M_din      (M_din),
        .S0_sel     (S0_sel),
        .S1_sel     (S1_sel),
        .S2_sel     (S2_sel),
        .S_wr       (S_wr),
        .S_address  (S_address),
        .S_dout     (S_dout),
        .S0_dout    (S0_dout),
        .S1_dout    (S1_dout),
        .S2_dout    (S2_dout)
    );

    // Slave models
    logic [31:0] s1_mem [0:31];

    always @(posedge clk) begin
        if (reset) begin
            S0_dout <= 32'h5A5A_0000;
            S1_dout <= 32'h5A5A_0001;
            S2_dout <= 32'h5A5A_0002;
        end else begin
            if (S1_sel && S_wr)  s1_mem[S_address[4:0]] <= S_dout;
            if (S0_sel && !S_wr) S0_dout <= 32'hA000_0000 | {24'h0, S_address};
            if (S1_sel && !S_wr) S1_dout <= s1_mem[S_address[4:0]];
            if (S2_sel && !S_wr) S2_dout <= 32'hB200_0000 | {24'h0, S_address};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        M0_req = 0; M1_req = 0; M0_wr = 0; M1_wr = 0;
        M0_address = 8'h25; M1_address = 8'h44;
        M0_dout = 32'h1111_1111; M1_dout = 32'h2222_2222;
        tick(); tick();
        reset = 1'b0;
        #1;
        vec_cnt++;
        if ({M0_grant, M1_grant} !== 2'b10) begin
            err_cnt++; $display("FAIL reset_grants got %b want 10", {M0_grant, M1_grant});
        end
        vec_cnt++;
        if (M_din !== 32'd0) begin
            err_cnt++; $display("FAIL reset_mdin got %h want 0", M_din);
        end
        vec_cnt++;
        if ({S0_sel, S1_sel, S2_sel} !== 3'b000 || S_address !== 8'h25) begin
            err_cnt++; $display("FAIL reset_idle sel %b addr %h want 000 25",
                                {S0_sel, S1_sel, S2_sel}, S_address);
        end
        $display("reset: grants=%b M_din=%h", {M0_grant, M1_grant}, M_din);
    endtask

    task automatic test_write_read();
        M0_req = 1; M0_wr = 1; M0_address = 8'h20; M0_dout = 32'd10;
        #1;
        vec_cnt++;
        if ({S0_sel, S1_sel, S2_sel} !== 3'b010 || S_dout !== 32'd10 || S_wr !== 1'b1) begin
            err_cnt++; $display("FAIL write_sel sel %b dout %h wr %b want 010 a 1",
                                {S0_sel, S1_sel, S2_sel}, S_dout, S_wr);
        end
        $display("write 0x20 <- 10: sel=%b", {S0_sel, S1_sel, S2_sel});
        tick();
        M0_wr = 0;
        #1;
        vec_cnt++;
        if (M_din !== 32'd0) begin
            err_cnt++; $display("FAIL write_no_return got %h want 0", M_din);
        end
        tick();
        M0_req = 0;
        #1;
        vec_cnt++;
        if (M_din !== 32'd10) begin
            err_cnt++; $display("FAIL read_0x20 got %h want 0000000a", M_din);
        end
        $display("read 0x20: M_din=%h", M_din);
        tick();
    endtask

    task automatic test_decode_sweep();
        M0_req = 1; M0_wr = 0; M0_address = 8'h03;
        tick();
        M0_address = 8'h41;
        #1;
        vec_cnt++;
        if (M_din !== 32'hA000_0003) begin
            err_cnt++; $display("FAIL sweep_s0 got %h want a0000003", M_din);
        end
        $display("sweep 0x03: M_din=%h", M_din);
        tick();
        M0_address = 8'h80;
        #1;
        vec_cnt++;
        if (M_din !== 32'hB200_0041) begin
            err_cnt++; $display("FAIL sweep_s2 got %h want b2000041", M_din);
        end
        vec_cnt++;
        if ({S0_sel, S1_sel, S2_sel} !== 3'b000) begin
            err_cnt++; $display("FAIL sweep_0x80_sel got %b want 000", {S0_sel, S1_sel, S2_sel});
        end
        $display("sweep 0x41: M_din=%h", M_din);
        tick();
        M0_req = 0;
        #1;
        vec_cnt++;
        if (M_din !== 32'd0) begin
            err_cnt++; $display("FAIL sweep_none got %h want 0", M_din);
        end
        $display("sweep 0x80: M_din=%h", M_din);
        tick();
    endtask

    task automatic test_handover();
        M0_req = 1; M0_wr = 0; M0_address = 8'h00;
        M1_req = 1; M1_wr = 1; M1_address = 8'h45; M1_dout = 32'h0000_CAFE;
        #1;
        vec_cnt++;
        if ({M0_grant, M1_grant} !== 2'b10 || S_address !== 8'h00) begin
            err_cnt++; $display("FAIL contend_m0 grants %b addr %h want 10 00",
                                {M0_grant, M1_grant}, S_address);
        end
        tick();
        M0_req = 0;
        #1;
        vec_cnt++;
        if ({M0_grant, M1_grant} !== 2'b10 || {S0_sel, S1_sel, S2_sel} !== 3'b000) begin
            err_cnt++; $display("FAIL drop_cycle grants %b sel %b want 10 000",
                                {M0_grant, M1_grant}, {S0_sel, S1_sel, S2_sel});
        end
        tick();
        vec_cnt++;
        if ({M0_grant, M1_grant} !== 2'b01) begin
            err_cnt++; $display("FAIL handover_m1 grants %b want 01", {M0_grant, M1_grant});
        end
        vec_cnt++;
        if (S_address !== 8'h45 || S_dout !== 32'h0000_CAFE || S_wr !== 1'b1 ||
            {S0_sel, S1_sel, S2_sel} !== 3'b001) begin
            err_cnt++; $display("FAIL m1_forward addr %h dout %h wr %b sel %b want 45 cafe 1 001",
                                S_address, S_dout, S_wr, {S0_sel, S1_sel, S2_sel});
        end
        $display("handover to M1: grants=%b S_address=%h", {M0_grant, M1_grant}, S_address);
    endtask

    task automatic test_m1_burst();
        int held;
        held = 0;
        M0_req = 1; M0_wr = 0; M0_address = 8'h03;
        M1_wr = 0; M1_address = 8'h42;
        for (int i = 0; i < 20; i++) begin
            #1;
            vec_cnt++;
            if ({M0_grant, M1_grant} !== 2'b01) begin
                err_cnt++; $display("FAIL burst_cycle%0d grants %b want 01", i, {M0_grant, M1_grant});
            end else begin
                held++;
            end
            tick();
        end
        $display("M1 burst: M1 kept bus %0d of 20 cycles", held);
        // M1 has read 0x42 in the previous cycle; it now drops req.
        M1_req = 0;
        #1;
        vec_cnt++;
        if (M_din !== 32'hB200_0042 || {M0_grant, M1_grant} !== 2'b01) begin
            err_cnt++; $display("FAIL release_cycle M_din %h grants %b want b2000042 01",
                                M_din, {M0_grant, M1_grant});
        end
        tick();
        vec_cnt++;
        if ({M0_grant, M1_grant} !== 2'b10 || S0_sel !== 1'b1) begin
            err_cnt++; $display("FAIL back_to_m0 grants %b S0_sel %b want 10 1",
                                {M0_grant, M1_grant}, S0_sel);
        end
        tick();
        M0_req = 0;
        #1;
        vec_cnt++;
        if (M_din !== 32'hA000_0003) begin
            err_cnt++; $display("FAIL m0_read_after got %h want a0000003", M_din);
        end
        $display("M1 release: grants=%b M_din=%h", {M0_grant, M1_grant}, M_din);
        tick();
    endtask

    task automatic test_guard();
        int owned;
        logic seen;
        owned = 0;
        seen = 1'b0;
        M0_req = 1; M1_req = 1; M0_wr = 0; M1_wr = 0;
        M0_address = 8'h01; M1_address = 8'h21;
        for (int i = 0; i < 30; i++) begin
            if (M1_grant) begin
                seen = 1'b1;
                break;
            end
            if (M0_grant) owned++;
            tick();
        end
        vec_cnt++;
`ifdef ARB_STARVE_GUARD_EN
        if (seen !== 1'b1 || owned != 4) begin
            err_cnt++; $display("FAIL guard_hold m1_granted %b m0_cycles %0d want 1 4", seen, owned);
        end
`else
        if (seen !== 1'b0 || owned != 30) begin
            err_cnt++; $display("FAIL strict_prio m1_granted %b m0_cycles %0d want 0 30", seen, owned);
        end
`endif
        $display("contention: M0 owned %0d cycles, M1 granted=%b", owned, seen);
        M0_req = 0; M1_req = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        M0_req = 0; M1_req = 1; M1_wr = 0; M1_address = 8'h42;
        tick();
        vec_cnt++;
        if (M1_grant !== 1'b1) begin
            err_cnt++; $display("FAIL mid_setup M1_grant got %b want 1", M1_grant);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        vec_cnt++;
        if ({M0_grant, M1_grant} !== 2'b10 || M_din !== 32'd0) begin
            err_cnt++; $display("FAIL mid_reset grants %b M_din %h want 10 0",
                                {M0_grant, M1_grant}, M_din);
        end
        $display("mid reset: grants=%b M_din=%h", {M0_grant, M1_grant}, M_din);
        M1_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_decode_sweep();
        test_handover();
        test_m1_burst();
        test_guard();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
